// File: rtl/eld_pkg.sv
// Shared BCD constants and the digit clamp used when loading
// externally supplied digit values.
package eld_pkg;

   localparam int          BCD_W   = 4;
   localparam logic [3:0]  BCD_MAX = 4'd9;

   function automatic logic [BCD_W-1:0] bcd_sat(input logic [BCD_W-1:0] digit);
      return (digit > BCD_MAX) ? BCD_MAX : digit;
   endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decade of the BCD counter: holds a digit, steps it up or down and
// reports the carry/borrow into the next decade combinationally.
module bcd_digit
   import eld_pkg::*;
(
   input  logic             input_clock,
   input  logic             input_reset,
   input  logic             step_in,
   input  logic             up_down,
   input  logic             load,
   input  logic [BCD_W-1:0] load_d,
   input  logic             clear,
   output logic [BCD_W-1:0] digit,
   output logic             step_out
);

   logic [BCD_W-1:0] r_digit;
   logic [BCD_W-1:0] w_next;
   logic             w_at_limit;

   always_comb begin
      w_at_limit = up_down ? (r_digit == BCD_MAX) : (r_digit == '0);
      if (up_down)
         w_next = w_at_limit ? '0 : r_digit + BCD_W'(1);
      else
         w_next = w_at_limit ? BCD_MAX : r_digit - BCD_W'(1);
   end

   assign step_out = step_in && w_at_limit;
   assign digit    = r_digit;

   always_ff @(posedge input_clock or posedge input_reset) begin
      if (input_reset)
         r_digit <= '0;
      else if (clear)
         r_digit <= '0;
      else if (load)
         r_digit <= bcd_sat(load_d);
      else if (step_in)
         r_digit <= w_next;
   end

endmodule

// File: rtl/bcd_tick_counter.sv
// Prescaled N-digit BCD up/down counter with synchronous clear and load;
// count, tick and carry_out all change on the edge that completes a period.
module bcd_tick_counter
   import eld_pkg::*;
#(
   parameter int CLK_DIV = 50_000_000,
   parameter int DIGITS  = 4
) (
   input  logic                    input_clock,
   input  logic                    input_reset,
   input  logic                    enable,
   input  logic                    up_down,
   input  logic                    clear,
   input  logic                    load,
   input  logic [BCD_W*DIGITS-1:0] load_value,
   output logic [BCD_W*DIGITS-1:0] count,
   output logic                    tick,
   output logic                    carry_out
);

   localparam int               PRE_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_DIV - 1);

   logic [PRE_W-1:0] r_pre;
   logic             r_tick;
   logic             r_carry;
   logic             w_tick_cond;
   logic             w_top_step;

   assign w_tick_cond = enable && (r_pre == PRE_LAST);

   // The step ripples from digit 0 upward; load/clear priority is resolved
   // inside each digit, so the raw tick condition feeds the chain.
   for (genvar g = 0; g < DIGITS; g++) begin : gen_digit
      logic             w_step_in;
      logic             w_step_out;
      logic [BCD_W-1:0] w_digit;

      if (g == 0) begin : gen_first
         assign w_step_in = w_tick_cond;
      end else begin : gen_chain
         assign w_step_in = gen_digit[g-1].w_step_out;
      end

      bcd_digit u_digit (
         .input_clock (input_clock),
         .input_reset (input_reset),
         .step_in     (w_step_in),
         .up_down     (up_down),
         .load        (load),
         .load_d      (load_value[g*BCD_W +: BCD_W]),
         .clear       (clear),
         .digit       (w_digit),
         .step_out    (w_step_out)
      );

      assign count[g*BCD_W +: BCD_W] = w_digit;
   end

   assign w_top_step = gen_digit[DIGITS-1].w_step_out;

   always_ff @(posedge input_clock or posedge input_reset) begin
      if (input_reset) begin
         r_pre   <= '0;
         r_tick  <= 1'b0;
         r_carry <= 1'b0;
      end else if (clear || load) begin
         r_pre   <= '0;
         r_tick  <= 1'b0;
         r_carry <= 1'b0;
      end else begin
         r_tick  <= w_tick_cond;
         r_carry <= w_top_step;
         if (w_tick_cond)
            r_pre <= '0;
         else if (enable)
            r_pre <= r_pre + PRE_W'(1);
      end
   end

   assign tick      = r_tick;
   assign carry_out = r_carry;

endmodule
